mem_bus_bridge: RTL and testbench
=================================

Name: mem_bus_bridge

Overview:
- Byte-addressed request bridge in front of the 16-bit word memory (19-bit word address, fixed 2-clock read latency, single-cycle write).
- Accepts CPU-side byte and word reads and writes at any 20-bit byte address.
- Splits unaligned word accesses into two word accesses.
- The memory has no byte enables, so byte and unaligned writes use read-modify-write.
- Drives the memory's read and write ports directly and ignores its write-readback port.

Parameters:
- RD_LAT, 2, memory read latency in clocks (edges from addr_rd change to q valid); all timings below are for RD_LAT=2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- req  in  1  request strobe; sampled on the rising edge
- we  in  1  1 = write, 0 = read (sampled with req)
- wide  in  1  1 = 16-bit word, 0 = byte (sampled with req)
- addr  in  20  byte address (sampled with req)
- din  in  16  write data; byte writes use din[7:0]
- busy  out  1  request in progress; req is ignored while high
- done  out  1  one-cycle completion pulse
- dout  out  16  read result, valid while done is high
- addr_rd  out  19  memory read word address (registered)
- q  in  16  memory read data
- addr_wr  out  19  memory write word address (registered)
- data_wr  out  16  memory write data (registered)
- wren  out  1  memory write enable (registered; one cycle per word written)

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - busy, done, wren, dout, addr_rd, addr_wr and data_wr all go to 0.
- Reset mid-operation:
  - Aborts immediately; no further wren.
  - An unaligned write may leave only its first word written. This is permitted.
- Accept: a rising edge with req=1 and busy=0 (edge E0).
  - The request is latched.
  - busy=1 from E0 until the edge that raises done; busy=0 during the done cycle.
  - A new request may be accepted on the edge that ends the done cycle.
- Addressing:
  - Word address A = addr[19:1].
  - Unaligned = wide & addr[0].
  - Second word is A+1 modulo 2^19, so 0x7FFFF wraps to 0x00000.
- Little-endian: the byte at an even address is bits [7:0].
- FSM states: IDLE, RD1, RD2, WAIT, WR1, WR2, DONE.
- Aligned word write:
  - E0: addr_wr=A, data_wr=din, wren=1.
  - E1: memory commits, wren=0, done=1.
- Reads and read-modify-write:
  - E0: addr_rd=A.
  - Unaligned only: E1 sets addr_rd=A+1.
  - qA is captured at E3. For unaligned accesses, qA1 is captured at E4.
- Byte read:
  - done=1 after E3.
  - dout = {8'h00, addr[0] ? qA[15:8] : qA[7:0]}.
- Aligned word read:
  - done after E3.
  - dout = qA.
- Unaligned word read:
  - done after E4.
  - dout = {qA1[7:0], qA[15:8]}.
- Byte write:
  - E3: wren=1, addr_wr=A, data_wr = addr[0] ? {din[7:0], qA[7:0]} : {qA[15:8], din[7:0]}.
  - E4: commit, done=1.
- Unaligned word write:
  - E4: wren=1, addr_wr=A, data_wr={din[7:0], qA[7:0]}.
  - E5: addr_wr=A+1, data_wr={qA1[15:8], din[15:8]}, wren stays 1.
  - E6: wren=0, done=1.
- done is high for exactly one cycle and dout holds its value until the next done.
- wren is never high in IDLE or DONE.
- Read-after-write ordering: done is raised only after the final write is committed, so the next request (accepted no earlier than the done edge) always reads the new data.
- Requests with busy=1 are dropped silently. There is no queueing.

Test Plan:
Memory is preloaded with word 0x00010 = 0x1234 and word 0x00011 = 0xABCD.
1. Word read at byte 0x00020 -> addr_rd=0x00010; done 3 clocks after accept; dout=0x1234; wren never asserted.
2. Byte reads at 0x00021 and 0x00020 -> dout=0x0012 and 0x0034, each with done at +3.
3. Unaligned word read at 0x00021 -> addr_rd 0x00010 then 0x00011 on consecutive cycles; done at +4; dout=0xCD12.
4. Byte write at 0x00021 with din=0x0077 -> one wren cycle, addr_wr=0x00010, data_wr=0x7734; done at +4. A following word read at 0x00020 returns 0x7734.
5. Unaligned word write at 0x00021 with din=0xBEEF -> two consecutive wren cycles writing 0x00010=0xEF34 and 0x00011=0xABBE; done at +6.
6. Wrap and reset:
   - Unaligned word read at 0xFFFFF -> addr_rd 0x7FFFF then 0x00000.
   - Separately, pull rst_n low during the second wren of an unaligned write -> wren, busy and done drop to 0 immediately, and the FSM accepts a new req after rst_n is released.
   - A req asserted while busy=1 produces no extra done.

Source files
------------

// File: rtl/mem_bus_bridge.sv
// Byte-addressed CPU bridge onto a 16-bit word memory: read-modify-write for bytes, split unaligned words.
// Done 1 clk after accept (aligned word write), RD_LAT+1/+2 (reads, byte write), RD_LAT+4 (unaligned write); req ignored while busy.
`timescale 1ns/1ps
module mem_bus_bridge #(
   parameter int RD_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic        wide,
   input  logic [19:0] addr,
   input  logic [15:0] din,
   output logic        busy,
   output logic        done,
   output logic [15:0] dout,
   output logic [18:0] addr_rd,
   input  logic [15:0] q,
   output logic [18:0] addr_wr,
   output logic [15:0] data_wr,
   output logic        wren
);

   typedef enum logic [2:0] {IDLE, RD1, RD2, WAIT, WR1, WR2, DONE} state_t;
   localparam int CW = $clog2(RD_LAT + 1);

   state_t        state, state_nxt;
   logic [CW-1:0] lat_cnt;
   logic          r_we, r_wide, second;
   logic [19:0]   r_addr;
   logic [15:0]   r_din, qa;
   logic [7:0]    qa1_hi;
   logic [18:0]   wa, wa1;
   logic          unal, cap;

   assign wa   = r_addr[19:1];
   assign wa1  = wa + 19'd1;
   assign unal = r_wide & r_addr[0];
   assign cap  = (state == WAIT) && (lat_cnt == '0);
   assign busy = (state != IDLE) && (state != DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (req) state_nxt = (we & wide & ~addr[0]) ? WR1 : RD1;
            else     state_nxt = IDLE;
         end
         RD1: state_nxt = RD2;
         RD2: state_nxt = WAIT;
         // an unaligned access stays one extra cycle in WAIT to catch word A+1
         WAIT: if (cap && !(unal && !second)) state_nxt = r_we ? WR1 : DONE;
         WR1: state_nxt = unal ? WR2 : DONE;
         WR2: state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         done  <= 1'b0;
         wren  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state_nxt == DONE);
         wren  <= (state_nxt == WR1) || (state_nxt == WR2);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_wide  <= 1'b0;
         r_addr  <= '0;
         r_din   <= '0;
         second  <= 1'b0;
         lat_cnt <= '0;
         qa      <= '0;
         qa1_hi  <= '0;
         dout    <= '0;
         addr_rd <= '0;
         addr_wr <= '0;
         data_wr <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (req) begin
                  r_we   <= we;
                  r_wide <= wide;
                  r_addr <= addr;
                  r_din  <= din;
                  second <= 1'b0;
                  if (we & wide & ~addr[0]) begin
                     addr_wr <= addr[19:1];
                     data_wr <= din;
                  end else begin
                     addr_rd <= addr[19:1];
                  end
               end
            end
            RD1: if (unal) addr_rd <= wa1;
            RD2: lat_cnt <= CW'(RD_LAT - 2);
            WAIT: begin
               if (!cap) begin
                  lat_cnt <= lat_cnt - CW'(1);
               end else if (!second) begin
                  qa <= q;
                  if (unal) begin
                     second <= 1'b1;
                  end else if (r_we) begin
                     addr_wr <= wa;
                     data_wr <= r_addr[0] ? {r_din[7:0], q[7:0]} : {q[15:8], r_din[7:0]};
                  end else begin
                     dout <= r_wide ? q : {8'h00, (r_addr[0] ? q[15:8] : q[7:0])};
                  end
               end else if (r_we) begin
                  qa1_hi  <= q[15:8];
                  addr_wr <= wa;
                  data_wr <= {r_din[7:0], qa[7:0]};
               end else begin
                  dout <= {q[7:0], qa[15:8]};
               end
            end
            WR1: begin
               if (unal) begin
                  addr_wr <= wa1;
                  data_wr <= {qa1_hi, r_din[15:8]};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Bench for mem_bus_bridge: 2-clock word memory model plus a byte-level reference memory.
`timescale 1ns/1ps
module tb_mem_bus_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0, we = 1'b0, wide = 1'b0;
   logic [19:0] addr = '0;
   logic [15:0] din = '0;
   logic        busy, done, wren;
   logic [15:0] dout, q, data_wr;
   logic [18:0] addr_rd, addr_wr;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] mem     [0:524287];
   logic [15:0] ref_mem [0:524287];
   logic [18:0] a1;
   logic [15:0] got;

   always #5 clk = ~clk;

   mem_bus_bridge #(.RD_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .wide(wide), .addr(addr),
      .din(din), .busy(busy), .done(done), .dout(dout), .addr_rd(addr_rd),
      .q(q), .addr_wr(addr_wr), .data_wr(data_wr), .wren(wren)
   );

   // memory device: address registered, data registered again -> 2-clock read latency
   always @(posedge clk) begin
      a1 <= addr_rd;
      q  <= mem[a1];
      if (wren) mem[addr_wr] = data_wr;
   end

   function automatic logic [15:0] dflt(input logic [18:0] i);
      return i[15:0] ^ {i[7:0], i[18:11]} ^ 16'h5A5A;
   endfunction

   function automatic logic [7:0] rbyte(input logic [19:0] b);
      logic [15:0] w;
      w = ref_mem[b[19:1]];
      return b[0] ? w[15:8] : w[7:0];
   endfunction

   task automatic wbyte(input logic [19:0] b, input logic [7:0] v);
      if (b[0]) ref_mem[b[19:1]][15:8] = v;
      else      ref_mem[b[19:1]][7:0]  = v;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // issue one request at the current negedge; returns at the negedge inside the done cycle
   task automatic do_req(input logic w, input logic wd, input logic [19:0] a,
                         input logic [15:0] d, input bit spam, output logic [15:0] res);
      logic [19:0] a2;
      logic [18:0] wa;
      logic        unal, direct;
      int          exp_lat, exp_wr, n, nwr;
      bit          busy_ok;
      logic [15:0] exp_dout;
      a2      = a + 20'd1;
      wa      = a[19:1];
      unal    = wd & a[0];
      direct  = w & wd & ~a[0];
      exp_lat = !w ? (unal ? 4 : 3) : (!wd ? 4 : (unal ? 6 : 1));
      exp_wr  = !w ? 0 : (unal ? 2 : 1);
      exp_dout = wd ? {rbyte(a2), rbyte(a)} : {8'h00, rbyte(a)};
      req = 1'b1; we = w; wide = wd; addr = a; din = d;
      @(posedge clk);
      #1;
      req = 1'b0; we = 1'($urandom); wide = 1'($urandom); addr = 20'($urandom); din = 16'($urandom);
      n = 0; nwr = 0; busy_ok = 1'b1;
      do begin
         @(negedge clk);
         n++;
         if (wren) nwr++;
         req = (spam && n <= 2);
         if (n == 1 && !direct) chk("addr_rd_first", addr_rd, wa);
         if (n == 2 && unal)    chk("addr_rd_second", addr_rd, 19'(wa + 19'd1));
         if (!done && !busy) busy_ok = 1'b0;
         if (done && busy)   busy_ok = 1'b0;
      end while (!done && n < 20);
      req = 1'b0;
      chk("done_latency", n - 1, exp_lat);
      chk("busy_profile", busy_ok, 1);
      chk("wren_cycles", nwr, exp_wr);
      if (!w) chk("dout", dout, exp_dout);
      if (w) begin
         wbyte(a, d[7:0]);
         if (wd) wbyte(a2, d[15:8]);
         chk("mem_word_a", mem[wa], ref_mem[wa]);
         chk("mem_word_a1", mem[a2[19:1]], ref_mem[a2[19:1]]);
      end
      res = dout;
   endtask

   task automatic idle_chk(input int k);
      int extra;
      extra = 0;
      repeat (k) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk("no_extra_done", extra, 0);
   endtask

   initial begin
      int n, nwr;
      logic        w, wd, sp;
      logic [19:0] a;
      for (int i = 0; i < 524288; i++) begin
         mem[i]     = dflt(19'(i));
         ref_mem[i] = mem[i];
      end
      mem[16] = 16'h1234; ref_mem[16] = 16'h1234;
      mem[17] = 16'hABCD; ref_mem[17] = 16'hABCD;

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wren", wren, 0);
      chk("rst_dout", dout, 0);
      chk("rst_addr_rd", addr_rd, 0);
      chk("rst_addr_wr", addr_wr, 0);
      chk("rst_data_wr", data_wr, 0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);

      do_req(1'b0, 1'b1, 20'h00020, 16'h0, 1'b0, got);
      chk("t1_word_read", got, 16'h1234);
      repeat (2) @(negedge clk);
      do_req(1'b0, 1'b0, 20'h00021, 16'h0, 1'b0, got);
      chk("t2_byte_hi", got, 16'h0012);
      do_req(1'b0, 1'b0, 20'h00020, 16'h0, 1'b0, got);
      chk("t2_byte_lo", got, 16'h0034);
      do_req(1'b0, 1'b1, 20'h00021, 16'h0, 1'b0, got);
      chk("t3_unaligned_read", got, 16'hCD12);
      do_req(1'b1, 1'b0, 20'h00021, 16'h0077, 1'b0, got);
      chk("t4_mem", mem[16], 16'h7734);
      do_req(1'b0, 1'b1, 20'h00020, 16'h0, 1'b0, got);
      chk("t4_readback", got, 16'h7734);
      do_req(1'b1, 1'b1, 20'h00021, 16'hBEEF, 1'b0, got);
      chk("t5_word_lo", mem[16], 16'hEF34);
      chk("t5_word_hi", mem[17], 16'hABBE);
      do_req(1'b0, 1'b1, 20'hFFFFF, 16'h0, 1'b0, got);
      do_req(1'b0, 1'b1, 20'h00020, 16'h0, 1'b1, got);
      idle_chk(4);

      // reset during the second write of an unaligned word write
      req = 1'b1; we = 1'b1; wide = 1'b1; addr = 20'h00041; din = 16'h5AA5;
      @(posedge clk);
      #1 req = 1'b0;
      n = 0; nwr = 0;
      while (nwr < 2 && n < 20) begin
         @(negedge clk);
         n++;
         if (wren) nwr++;
      end
      chk("rst_mid_reached_second_wren", nwr, 2);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_wren", wren, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
      wbyte(20'h00041, 8'hA5);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_first_word", mem[19'h20], ref_mem[19'h20]);
      chk("rst_mid_second_word", mem[19'h21], ref_mem[19'h21]);
      do_req(1'b0, 1'b1, 20'h00041, 16'h0, 1'b0, got);

      repeat (60) begin
         w  = 1'($urandom);
         wd = 1'($urandom);
         case ($urandom_range(0, 3))
            0:       a = 20'h00020 + 20'($urandom_range(0, 7));
            1:       a = 20'hFFFF8 + 20'($urandom_range(0, 7));
            2:       a = 20'h00040 + 20'($urandom_range(0, 3));
            default: a = 20'($urandom);
         endcase
         sp = !w && ($urandom_range(0, 3) == 0);
         do_req(w, wd, a, 16'($urandom), sp, got);
         if (sp) idle_chk(3);
         else if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
